// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (difference = A - B), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add a registered two's-complement overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] difference_q;
  logic             borrow_q;

  logic [1:0]       step_d;
  logic             bit_d;
  logic             bout_d;
  logic [WIDTH-1:0] res_d;

  // Half-subtractor cell extended with the incoming borrow; returns {borrow_out, diff}.
  function automatic logic [1:0] fsub_step(input logic a, input logic b, input logic bin);
    logic hd;
    logic hb;
    hd = a ^ b;
    hb = ~a & b;
    return {hb | (~hd & bin), hd ^ bin};
  endfunction

  // Current bit's difference/borrow and the result register after shifting it in.
  always_comb begin
    step_d = fsub_step(a_sh_q[0], b_sh_q[0], bin_q);
    bit_d  = step_d[0];
    bout_d = step_d[1];
    res_d  = {bit_d, res_q[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic overflow_q;

  // Operand sign capture and overflow result, registered alongside difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_msb_q <= A[WIDTH-1];
      b_msb_q <= B[WIDTH-1];
    end else if (state_q == SHIFT && cnt_q == CNT_LAST) begin
      // bit_d here is the final result MSB
      overflow_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign overflow = overflow_q;
`endif

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      bin_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      difference_q <= '0;
      borrow_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            res_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_q  <= res_d;
          bin_q  <= bout_d;
          if (cnt_q == CNT_LAST) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            difference_q <= res_d;
            borrow_q     <= bout_d;
            state_q      <= DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= SHIFT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = difference_q;
  assign borrow     = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] difference;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_diff = 8'h00;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .difference (difference),
`ifdef SERIAL_SUB_OVF_EN
    .overflow   (overflow),
`endif
    .borrow     (borrow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation with start held high throughout (back-to-back mode).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] ed;
    logic eb;
    ed = a - b;
    eb = (a < b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk); #1;
    check_val("busy_after_accept", {31'd0, busy}, 32'd1);
    check_val("diff_held", {24'd0, difference}, {24'd0, prev_diff});
    A = ~a;
    B = ~b;
    n = 0;
    while (!done && n < W + 2) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("latency", n, W);
    check_val("difference", {24'd0, difference}, {24'd0, ed});
    check_val("borrow", {31'd0, borrow}, {31'd0, eb});
    check_val("busy_in_done", {31'd0, busy}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_val("overflow", {31'd0, overflow},
              {31'd0, (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1])});
`endif
    prev_diff = ed;
    @(posedge clk); #1;
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
    check_val("start_ignored_in_done", {31'd0, busy}, 32'd0);
  endtask

  logic [W-1:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81,
                              8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_diff", {24'd0, difference}, 32'd0);
    check_val("rst_borrow", {31'd0, borrow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(8'h2D, 8'h0F);
    run_op(8'h05, 8'h0A);
    run_op(8'h80, 8'h01);
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        run_op(vals[i], vals[j]);
      end
    end

    // start pulsed mid-SHIFT must not launch a second operation
    A = 8'h40;
    B = 8'h03;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'h01;
    B = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < W + 6; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check_val("single_done", dones, 1);
    check_val("diff_after_pulse", {24'd0, difference}, 32'h3D);
    check_val("busy_after_pulse", {31'd0, busy}, 32'd0);

    // reset at T+4 aborts the operation
    A = 8'h03;
    B = 8'h09;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_diff", {24'd0, difference}, 32'd0);
    check_val("abort_borrow", {31'd0, borrow}, 32'd0);
    dones = 0;
    for (int k = 0; k < W + 2; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check_val("abort_no_done", dones, 0);
    prev_diff = 8'h00;
    run_op(8'h2D, 8'h0F);
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
